// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage load/store unit and the data memory.
// Latency: none, wires only; the master registers everything it drives.
// Backpressure: master holds its request stable until dmem_gnt_i, then waits for dmem_rvalid_i.
//
// Ports (master view):
//   dmem_req_o    request valid          dmem_gnt_i     memory accepts request
//   dmem_we_o     1 = write              dmem_rvalid_i  read data / write ack valid
//   dmem_addr_o   word-aligned address   dmem_rdata_i   read word
//   dmem_wdata_o  lane-replicated data
//   dmem_be_o     byte enables
interface mem_access_stage_if #(
    parameter int DATA_W = 32
);
    logic                  dmem_req_o;
    logic                  dmem_we_o;
    logic [DATA_W-1:0]     dmem_addr_o;
    logic [DATA_W-1:0]     dmem_wdata_o;
    logic [DATA_W/8-1:0]   dmem_be_o;
    logic                  dmem_gnt_i;
    logic                  dmem_rvalid_i;
    logic [DATA_W-1:0]     dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: EX/MEM controls -> req/gnt/rvalid data-memory transaction, load/store formatting.
// Latency: non-memory ops and misaligned accesses complete in 0 cycles; best-case memory op completes 2 cycles after accept.
// Backpressure: stall_o holds upstream from accept until the completing cycle (rvalid, timeout or flush-before-grant).
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid_i        EX/MEM holds a valid instruction
//   mem_read_i/_write_i, funct3_i, addr_i, store_data_i, reg_write_i   EX/MEM controls and operands
//   flush_i           kill the current instruction
//   stall_o           hold PC .. EX/MEM
//   wb_valid_o, wb_reg_write_o, load_data_o   MEM/WB capture
//   misalign_o, bus_err_o                     exception pulses
//   dmem              data-memory bus (master modport)
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid_i,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic [2:0]          funct3_i,
    input  logic [DATA_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic                reg_write_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                wb_valid_o,
    output logic                wb_reg_write_o,
    output logic [DATA_W-1:0]   load_data_o,
    output logic                misalign_o,
    output logic                bus_err_o,
    mem_access_stage_if.master  dmem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    // The counter holds the number of REQ/RESP cycles already spent, so the
    // cycle that would be the TIMEOUT-th one is the one that errors out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   flushed_q, flushed_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W/8-1:0]    be_q, be_d;
    logic [2:0]             f3_q, f3_d;
    logic [1:0]             lane_q, lane_d;

    logic                   mem_op;
    logic                   misaligned;
    logic                   timeout_hit;
    logic [DATA_W/8-1:0]    be_fmt;
    logic [DATA_W-1:0]      wdata_fmt;
    logic [DATA_W-1:0]      rd_shift;
    logic [DATA_W-1:0]      ld_fmt;

    assign mem_op      = in_valid_i & (mem_read_i | mem_write_i);
    assign misaligned  = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                         ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    assign timeout_hit = (cnt_q == TO_LAST);

    // Store formatting: replicate the operand into every lane and let the
    // byte enables pick the lane, so memory never has to shift.
    always_comb begin
        be_fmt    = '1;
        wdata_fmt = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << addr_i[1:0];
                wdata_fmt = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_fmt = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load formatting uses the latched lane/size, not the live inputs.
    assign rd_shift = dmem.dmem_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        ld_fmt = dmem.dmem_rdata_i;
        case (f3_q)
            3'b000:  ld_fmt = {{(DATA_W-8){rd_shift[7]}},   rd_shift[7:0]};
            3'b100:  ld_fmt = {{(DATA_W-8){1'b0}},          rd_shift[7:0]};
            3'b001:  ld_fmt = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  ld_fmt = {{(DATA_W-16){1'b0}},         rd_shift[15:0]};
            default: ld_fmt = dmem.dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        stall_o     = 1'b0;
        wb_valid_o  = 1'b0;
        load_data_o = '0;
        misalign_o  = 1'b0;
        bus_err_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!mem_op) begin
                    wb_valid_o = in_valid_i & ~flush_i;
                end else if (misaligned) begin
                    misalign_o = 1'b1;
                    wb_valid_o = 1'b1;
                end else if (!flush_i) begin
                    stall_o   = 1'b1;
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                    req_d     = 1'b1;
                    we_d      = mem_write_i;
                    addr_d    = {addr_i[DATA_W-1:2], 2'b00};
                    wdata_d   = wdata_fmt;
                    be_d      = be_fmt;
                    f3_d      = funct3_i;
                    lane_d    = addr_i[1:0];
                end
                // An aligned memory op flushed while still in IDLE simply dies.
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // Nothing has reached memory yet, so a flush can abort cleanly.
                if (flush_i) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else if (timeout_hit) begin
                    bus_err_o  = 1'b1;
                    wb_valid_o = 1'b1;
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                end else if (dmem.dmem_gnt_i) begin
                    stall_o = 1'b1;
                    state_d = S_RESP;
                    req_d   = 1'b0;
                end else begin
                    stall_o = 1'b1;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 8'd1;
                // The access is committed in memory; a flush only suppresses write-back.
                if (dmem.dmem_rvalid_i) begin
                    wb_valid_o  = ~(flushed_q | flush_i);
                    load_data_o = we_q ? '0 : ld_fmt;
                    state_d     = S_IDLE;
                end else if (timeout_hit) begin
                    bus_err_o  = 1'b1;
                    wb_valid_o = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (flush_i) begin
                        flushed_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wb_reg_write_o = reg_write_i & wb_valid_o & ~misalign_o & ~bus_err_o;

        if (rst) begin
            stall_o        = 1'b0;
            wb_valid_o     = 1'b0;
            wb_reg_write_o = 1'b0;
            load_data_o    = '0;
            misalign_o     = 1'b0;
            bus_err_o      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flushed_q <= flushed_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            f3_q      <= f3_d;
            lane_q    <= lane_d;
        end
    end

    assign dmem.dmem_req_o   = req_q;
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = addr_q;
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_be_o    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: transaction-level model predicts every cycle's outputs.
// Latency: driver pushes the expected outputs of a cycle right after driving it.
// Backpressure: the driver holds the instruction stable for as long as the model says it stalls.
module tb_mem_access_stage;

    localparam int TO = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, reg_write, flush;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        stall, wb_valid, wb_reg_write, misalign, bus_err;
    logic [31:0] load_data;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(32)) bus ();

    mem_access_stage #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .funct3_i       (funct3),
        .addr_i         (addr),
        .store_data_i   (store_data),
        .reg_write_i    (reg_write),
        .flush_i        (flush),
        .stall_o        (stall),
        .wb_valid_o     (wb_valid),
        .wb_reg_write_o (wb_reg_write),
        .load_data_o    (load_data),
        .misalign_o     (misalign),
        .bus_err_o      (bus_err),
        .dmem           (bus)
    );

    typedef struct {
        bit          stall, wbv, wbw, mis, berr, req, chk_req, we;
        logic [31:0] ld, addr, wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // Observations of the DUT used by the hand-computed directed checks.
    int          stall_cnt = 0, req_cnt = 0, berr_cnt = 0, wbv_cnt = 0;
    logic [31:0] last_ld, last_wd;
    logic [3:0]  last_be;
    logic        last_we, last_wbw, last_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- specification-level model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] lane_mask(input int s);
        return (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        logic [31:0] m = ((32'd1 << s) - 32'd1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
        int s = size_of(f3);
        logic [31:0] rep = (s == 1) ? 32'h0101_0101 : (s == 2) ? 32'h0001_0001 : 32'd1;
        return (d & lane_mask(s)) * rep;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int s = size_of(f3);
        logic [31:0] m = lane_mask(s);
        logic [31:0] v = (w >> (8 * a[1:0])) & m;
        if (s < 4 && !f3[2] && v[8*s-1]) v = v | ~m;
        return v;
    endfunction

    // ---------------- compare process ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall",        32'(stall),        32'(e.stall));
                chk("wb_valid",     32'(wb_valid),     32'(e.wbv));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.wbw));
                chk("misalign",     32'(misalign),     32'(e.mis));
                chk("bus_err",      32'(bus_err),      32'(e.berr));
                chk("load_data",    load_data,         e.ld);
                if (e.chk_req) chk("dmem_req", 32'(bus.dmem_req_o), 32'(e.req));
                if (e.chk_req && e.req) begin
                    chk("dmem_we",    32'(bus.dmem_we_o), 32'(e.we));
                    chk("dmem_addr",  bus.dmem_addr_o,    e.addr);
                    chk("dmem_be",    32'(bus.dmem_be_o), 32'(e.be));
                    chk("dmem_wdata", bus.dmem_wdata_o,   e.wdata);
                end
            end
            if (stall)          stall_cnt++;
            if (bus.dmem_req_o) begin
                req_cnt++;
                last_be = bus.dmem_be_o;
                last_wd = bus.dmem_wdata_o;
                last_we = bus.dmem_we_o;
            end
            if (bus_err)  berr_cnt++;
            if (misalign) last_mis = 1'b1;
            if (wb_valid) begin
                wbv_cnt++;
                last_ld  = load_data;
                last_wbw = wb_reg_write;
            end
        end
    end

    // ---------------- driver + model ----------------
    // g: cycles of gnt held low before grant; r: RESP cycles until rvalid (>=1).
    // fl_req/fl_resp: 1-based cycle within that phase carrying flush (0 = none).
    // rst_at: 1-based REQ/RESP cycle at which reset hits (0 = none).
    task automatic run(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input bit rw,
                       input int g, input int r, input logic [31:0] rdv,
                       input bit fl_idle, input int fl_req, input int fl_resp, input int rst_at);
        exp_t e;
        bit   mop, flushed;
        int   n;
        mop = v && (rd || wr);
        @(posedge clk); #1;
        rst = 0; in_valid = v; mem_read = rd; mem_write = wr; funct3 = f3;
        addr = a; store_data = d; reg_write = rw; flush = fl_idle;
        bus.dmem_gnt_i = 1'($urandom); bus.dmem_rvalid_i = 1'($urandom); bus.dmem_rdata_i = $urandom;
        e = '{default: 0}; e.chk_req = 1;
        if (!mop) begin
            e.wbv = v && !fl_idle; e.wbw = rw && e.wbv;
            expq.push_back(e); return;
        end
        if (is_misal(f3, a)) begin
            e.mis = 1; e.wbv = 1;
            expq.push_back(e); return;
        end
        if (fl_idle) begin
            expq.push_back(e); return;
        end
        e.stall = 1; expq.push_back(e);
        n = 0; flushed = 0;
        for (int i = 1; i <= g + 1; i++) begin
            @(posedge clk); #1; n++;
            bus.dmem_gnt_i = (i == g + 1); bus.dmem_rvalid_i = 1'($urandom);
            bus.dmem_rdata_i = $urandom; flush = (i == fl_req);
            e = '{default: 0}; e.chk_req = 1; e.req = 1; e.we = wr;
            e.addr = a & ~32'd3; e.be = exp_be(f3, a); e.wdata = exp_wd(f3, d);
            if (n == rst_at) begin rst = 1; e.chk_req = 0; expq.push_back(e); return; end
            if (flush)       begin expq.push_back(e); return; end
            if (n == TO)     begin e.berr = 1; e.wbv = 1; expq.push_back(e); return; end
            e.stall = 1; expq.push_back(e);
        end
        for (int j = 1; j <= r; j++) begin
            @(posedge clk); #1; n++;
            bus.dmem_gnt_i = 1'($urandom); bus.dmem_rvalid_i = (j == r);
            bus.dmem_rdata_i = (j == r) ? rdv : $urandom; flush = (j == fl_resp);
            if (flush) flushed = 1;
            e = '{default: 0}; e.chk_req = 1;
            if (n == rst_at) begin rst = 1; e.chk_req = 0; expq.push_back(e); return; end
            if (j == r) begin
                e.wbv = !flushed; e.wbw = rw && e.wbv;
                e.ld = rd ? exp_ld(f3, a, rdv) : 32'd0;
                expq.push_back(e); return;
            end
            if (n == TO) begin e.berr = 1; e.wbv = 1; expq.push_back(e); return; end
            e.stall = 1; expq.push_back(e);
        end
    endtask

    initial begin
        int s0, r0, b0, w0;
        exp_t e;
        logic [2:0] f3s [5];
        f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;

        // Reset with a valid aligned load presented: combinational outputs stay 0.
        rst = 1; in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010;
        addr = 32'h100; store_data = 0; reg_write = 1; flush = 0;
        bus.dmem_gnt_i = 1; bus.dmem_rvalid_i = 1; bus.dmem_rdata_i = 32'h1234_5678;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            e = '{default: 0}; e.chk_req = 1;
            expq.push_back(e);
        end

        // 1: LW, best case.
        s0 = stall_cnt;
        run(1, 1, 0, 3'b010, 32'h100, 0, 1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        @(posedge clk); #1; in_valid = 0; expq.push_back('{default: 0, chk_req: 1});
        @(negedge clk);
        chk("t1_load_data", last_ld, 32'hDEAD_BEEF);
        chk("t1_stall_cycles", 32'(stall_cnt - s0), 32'd2);

        // 2: byte/half loads with extension.
        run(1, 1, 0, 3'b000, 32'h103, 0, 1, 0, 1, 32'h8011_2233, 0, 0, 0, 0);
        @(negedge clk); chk("t2_lb", last_ld, 32'hFFFF_FF80);
        run(1, 1, 0, 3'b100, 32'h103, 0, 1, 1, 2, 32'h8011_2233, 0, 0, 0, 0);
        @(negedge clk); chk("t2_lbu", last_ld, 32'h0000_0080);
        run(1, 1, 0, 3'b101, 32'h102, 0, 1, 0, 1, 32'h8011_2233, 0, 0, 0, 0);
        @(negedge clk); chk("t2_lhu", last_ld, 32'h0000_8011);

        // 3: SH upper half.
        run(1, 0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 0, 0, 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_be", 32'(last_be), 32'hC);
        chk("t3_wdata", last_wd, 32'hABCD_ABCD);
        chk("t3_we", 32'(last_we), 32'd1);
        chk("t3_wbw", 32'(last_wbw), 32'd0);

        // 4: misaligned LW never reaches the bus.
        r0 = req_cnt; s0 = stall_cnt; last_mis = 0;
        run(1, 1, 0, 3'b010, 32'h101, 0, 1, 0, 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_misalign", 32'(last_mis), 32'd1);
        chk("t4_no_req", 32'(req_cnt - r0), 32'd0);
        chk("t4_no_stall", 32'(stall_cnt - s0), 32'd0);

        // 5: slow grant and slow response.
        s0 = stall_cnt;
        run(1, 1, 0, 3'b010, 32'h200, 0, 1, 5, 3, 32'hCAFE_F00D, 0, 0, 0, 0);
        @(negedge clk);
        chk("t5_stall_cycles", 32'(stall_cnt - s0), 32'd9);
        chk("t5_load_data", last_ld, 32'hCAFE_F00D);

        // 6: grant never comes -> bus error; flush in REQ -> no write-back.
        b0 = berr_cnt;
        run(1, 1, 0, 3'b010, 32'h300, 0, 1, 40, 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_bus_err", 32'(berr_cnt - b0), 32'd1);
        w0 = wbv_cnt;
        run(1, 1, 0, 3'b010, 32'h300, 0, 1, 3, 1, 32'h0, 0, 2, 0, 0);
        run(0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk); chk("t6_flush_no_wb", 32'(wbv_cnt - w0), 32'd0);

        // Flush during RESP, then reset mid-transaction followed by a stray rvalid.
        run(1, 1, 0, 3'b010, 32'h400, 0, 1, 1, 3, 32'h55AA_55AA, 0, 0, 2, 0);
        run(1, 0, 1, 3'b000, 32'h401, 32'h77, 0, 2, 2, 32'h0, 0, 0, 0, 2);
        run(0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            int kind = $urandom_range(0, 9);
            int g = $urandom_range(0, 3);
            int r = $urandom_range(1, 3);
            bit v = (kind != 0);
            bit rd = (kind >= 2 && kind <= 5);
            bit wr = (kind >= 6);
            logic [2:0] f3 = f3s[$urandom_range(0, 4)];
            logic [31:0] a = $urandom;
            int fr = (g > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(1, g) : 0;
            int fs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, r) : 0;
            int ra = ($urandom_range(0, 19) == 0) ? $urandom_range(1, g + 1 + r) : 0;
            if (wr && f3[2]) f3 = 3'b000;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run(v, rd, wr, f3, a, $urandom, 1'($urandom), g, r, $urandom,
                ($urandom_range(0, 9) == 0), fr, fs, ra);
        end

        @(posedge clk); #1; rst = 0; in_valid = 0; mem_read = 0; mem_write = 0; flush = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
